// File: rtl/accum_ctrl.sv
// accum_ctrl: sequences a partial-sum stream into one accumulator instance.
// Assigns each beat its accumulator address, accumulate flag and last-subset
// flag, stalls the stream to keep same-address issues HAZ cycles apart, and
// pulses done once every result of the vector has left the accumulator.
module accum_ctrl #(
  parameter int unsigned DATAW = 32,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned ADDRW = 9,
  parameter int unsigned SUBW  = 8,
  parameter int unsigned HAZ   = 4
) (
  input  logic             clk,
  input  logic             rst,
  // configuration
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ADDRW-1:0] cfg_rows_m1,
  input  logic [SUBW-1:0]  cfg_subs_m1,
  input  logic [ADDRW-1:0] cfg_base,
  // partial-sum stream
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DATAW-1:0] s_data,
  // accumulator issue
  output logic             acc_valid,
  output logic [DATAW-1:0] acc_data,
  output logic [ADDRW-1:0] acc_addr,
  output logic             acc_accum,
  output logic             acc_last,
  input  logic             acc_o_valid,
  // status
  output logic             busy,
  output logic             done
);

  // History length; HAZ == 1 needs no history, one dummy slot is kept and masked.
  localparam int unsigned HistN = (HAZ > 1) ? HAZ - 1 : 1;
  // Output counter must reach rows_m1 + 1, i.e. up to 2**ADDRW.
  localparam int unsigned CntW  = ADDRW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;

  // latched configuration
  logic [ADDRW-1:0] r_rows_m1;
  logic [SUBW-1:0]  r_subs_m1;
  logic [ADDRW-1:0] r_base;

  // position within the vector
  logic [ADDRW-1:0] r_row;
  logic [SUBW-1:0]  r_sub;
  logic [CntW-1:0]  r_outcnt;

  // per-cycle issue history: slot 0 is the previous cycle
  logic [HistN-1:0] r_hist_vld;
  logic [ADDRW-1:0] r_hist_addr [HistN];

  // registered outputs
  logic             r_acc_valid;
  logic [DATAW-1:0] r_acc_data;
  logic [ADDRW-1:0] r_acc_addr;
  logic             r_acc_accum;
  logic             r_acc_last;
  logic             r_done;

  logic             w_cfg_fire;
  logic             w_beat;
  logic             w_s_ready;
  logic             w_hazard;
  logic             w_row_wrap;
  logic             w_sub_last;
  logic [ADDRW:0]   w_addr_sum;
  logic [ADDRW-1:0] w_next_addr;
  logic [CntW-1:0]  w_rows;
  logic [CntW-1:0]  w_outcnt_nxt;
  logic             w_count_en;
  logic             w_drain_done;
  logic             w_done_nxt;

  // Handshake and position decode.
  always_comb begin
    w_cfg_fire   = (r_state == StIdle) && cfg_valid;
    w_row_wrap   = (r_row == r_rows_m1);
    w_sub_last   = (r_sub == r_subs_m1);
    w_s_ready    = (r_state == StRun) && !w_hazard;
    w_beat       = s_valid && w_s_ready;
    w_rows       = {1'b0, r_rows_m1} + CntW'(1);
    w_count_en   = (r_state != StIdle) && acc_o_valid;
    w_outcnt_nxt = r_outcnt + CntW'(w_count_en);
    // >= keeps the drain from hanging if a surplus pulse ever arrives
    w_drain_done = (r_state == StDrain) && (w_outcnt_nxt >= w_rows);
  end

  // Next accumulator address: base + row, wrapping modulo DEPTH.
  always_comb begin
    w_addr_sum = {1'b0, r_base} + {1'b0, r_row};
    if (w_addr_sum >= (ADDRW + 1)'(DEPTH)) begin
      w_next_addr = ADDRW'(w_addr_sum - (ADDRW + 1)'(DEPTH));
    end else begin
      w_next_addr = w_addr_sum[ADDRW-1:0];
    end
  end

  // Stall when the next address was issued within the last HAZ-1 cycles.
  // Depends only on registered state so s_ready never follows s_valid.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < int'(HistN); i++) begin
      if ((HAZ > 1) && r_hist_vld[i] && (r_hist_addr[i] == w_next_addr)) begin
        w_hazard = 1'b1;
      end
    end
  end

  // FSM next state and done pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (cfg_valid) begin
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        if (w_beat && w_row_wrap && w_sub_last) begin
          w_state_nxt = StDrain;
        end
      end
      StDrain: begin
        if (w_drain_done) begin
          w_state_nxt = StIdle;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Configuration latch, row/subset position and output counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rows_m1 <= '0;
      r_subs_m1 <= '0;
      r_base    <= '0;
      r_row     <= '0;
      r_sub     <= '0;
      r_outcnt  <= '0;
    end else if (w_cfg_fire) begin
      r_rows_m1 <= cfg_rows_m1;
      r_subs_m1 <= cfg_subs_m1;
      r_base    <= cfg_base;
      r_row     <= '0;
      r_sub     <= '0;
      r_outcnt  <= '0;
    end else begin
      if (w_beat) begin
        if (w_row_wrap) begin
          r_row <= '0;
          r_sub <= r_sub + SUBW'(1);
        end else begin
          r_row <= r_row + ADDRW'(1);
        end
      end
      if (w_count_en) begin
        r_outcnt <= w_outcnt_nxt;
      end
    end
  end

  // Issue history shifts every cycle, bubbles included, so entries age out by time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist_vld <= '0;
      for (int i = 0; i < int'(HistN); i++) begin
        r_hist_addr[i] <= '0;
      end
    end else begin
      r_hist_vld[0]  <= w_beat;
      r_hist_addr[0] <= w_next_addr;
      for (int i = 1; i < int'(HistN); i++) begin
        r_hist_vld[i]  <= r_hist_vld[i-1];
        r_hist_addr[i] <= r_hist_addr[i-1];
      end
    end
  end

  // Accumulator issue registers, loaded from each accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc_valid <= 1'b0;
      r_acc_data  <= '0;
      r_acc_addr  <= '0;
      r_acc_accum <= 1'b0;
      r_acc_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_acc_valid <= w_beat;
      r_done      <= w_done_nxt;
      if (w_beat) begin
        r_acc_data  <= s_data;
        r_acc_addr  <= w_next_addr;
        r_acc_accum <= (r_sub != '0);
        r_acc_last  <= w_sub_last;
      end
    end
  end

  // Output drive.
  always_comb begin
    cfg_ready = (r_state == StIdle);
    busy      = (r_state != StIdle);
    s_ready   = w_s_ready;
    acc_valid = r_acc_valid;
    acc_data  = r_acc_data;
    acc_addr  = r_acc_addr;
    acc_accum = r_acc_accum;
    acc_last  = r_acc_last;
    done      = r_done;
  end

endmodule

// File: tb/tb_accum_ctrl.sv
// tb_accum_ctrl: randomized scoreboard bench for accum_ctrl with a behavioural
// accumulator and a vector-level reference model.
module tb_accum_ctrl;

  localparam int DATAW = 32;
  localparam int DEPTH = 512;
  localparam int ADDRW = 9;
  localparam int SUBW  = 8;
  localparam int HAZ   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [ADDRW-1:0] cfg_rows_m1;
  logic [SUBW-1:0]  cfg_subs_m1;
  logic [ADDRW-1:0] cfg_base;
  logic             s_valid;
  logic             s_ready;
  logic [DATAW-1:0] s_data;
  logic             acc_valid;
  logic [DATAW-1:0] acc_data;
  logic [ADDRW-1:0] acc_addr;
  logic             acc_accum;
  logic             acc_last;
  logic             acc_o_valid;
  logic             busy;
  logic             done;

  accum_ctrl #(
    .DATAW(DATAW), .DEPTH(DEPTH), .ADDRW(ADDRW), .SUBW(SUBW), .HAZ(HAZ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_rows_m1(cfg_rows_m1),
    .cfg_subs_m1(cfg_subs_m1),
    .cfg_base   (cfg_base),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .acc_valid  (acc_valid),
    .acc_data   (acc_data),
    .acc_addr   (acc_addr),
    .acc_accum  (acc_accum),
    .acc_last   (acc_last),
    .acc_o_valid(acc_o_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          addr;
    bit          accum;
    bit          last;
    logic [31:0] data;
  } issue_t;

  typedef struct {
    int          due;
    logic [31:0] val;
  } res_t;

  issue_t      exp_q[$];   // expected issues, in order
  logic [31:0] sum_q[$];   // expected final row sums, in completion order
  res_t        res_q[$];   // accumulator model results awaiting output

  logic [31:0] acc_mem  [DEPTH];
  logic [31:0] exp_sum  [DEPTH];
  int          beat_cyc [DEPTH];
  int          last_acc [DEPTH];

  // Reference model state: 0 idle, 1 accepting beats, 2 draining.
  int m_phase = 0;
  int m_k     = 0;
  int m_total = 1;
  int m_rows  = 1;
  int m_subs  = 1;
  int m_base  = 0;
  int m_outcnt = 0;
  bit m_done_exp = 0;

  function automatic int addr_of(input int k);
    return (m_base + (k % m_rows)) % DEPTH;
  endfunction

  // Reference model: checks status outputs and predicts each issue.
  always @(negedge clk) begin
    if (!rst) begin
      m_phase = 0; m_k = 0; m_outcnt = 0; m_done_exp = 0;
      exp_q.delete();
      sum_q.delete();
      for (int i = 0; i < DEPTH; i++) beat_cyc[i] = -1000;
    end else begin
      bit er;
      er = 0;
      if (m_phase == 1) er = (cyc - beat_cyc[addr_of(m_k)]) >= HAZ;
      chk("cfg_ready", cfg_ready, m_phase == 0);
      chk("busy", busy, m_phase != 0);
      chk("done", done, m_done_exp);
      chk("s_ready", s_ready, er);
      m_done_exp = 0;
      if (m_phase == 0) begin
        if (cfg_valid) begin
          m_rows = int'(cfg_rows_m1) + 1;
          m_subs = int'(cfg_subs_m1) + 1;
          m_base = int'(cfg_base);
          m_total = m_rows * m_subs;
          m_k = 0; m_outcnt = 0; m_phase = 1;
        end
      end else begin
        if (m_phase == 1 && s_valid && s_ready) begin
          int r, s, a;
          issue_t it;
          r = m_k % m_rows;
          s = m_k / m_rows;
          a = addr_of(m_k);
          it.addr = a; it.accum = (s != 0); it.last = (s == m_subs - 1); it.data = s_data;
          exp_q.push_back(it);
          exp_sum[r] = (s == 0) ? s_data : exp_sum[r] + s_data;
          if (s == m_subs - 1) sum_q.push_back(exp_sum[r]);
          beat_cyc[a] = cyc;
          m_k++;
          if (m_k == m_total) m_phase = 2;
        end
        if (acc_o_valid) begin
          m_outcnt++;
          if (m_phase == 2 && m_outcnt == m_rows) begin
            m_done_exp = 1;
            m_phase = 0;
          end
        end
      end
    end
  end

  // Monitor: pops expected issues on acc_valid and feeds the accumulator model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) last_acc[i] = -1000;
    end else if (acc_valid) begin
      int a;
      res_t rr;
      a = int'(acc_addr);
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", 1'b1, 1'b0);
      end else begin
        issue_t e;
        e = exp_q.pop_front();
        chk("acc_addr", acc_addr, e.addr);
        chk("acc_accum", acc_accum, e.accum);
        chk("acc_last", acc_last, e.last);
        chk("acc_data", acc_data, e.data);
      end
      if (last_acc[a] >= 0) chk("same_addr_gap_ok", (cyc - last_acc[a]) >= HAZ, 1'b1);
      last_acc[a] = cyc;
      acc_mem[a] = acc_accum ? acc_mem[a] + acc_data : acc_data;
      if (acc_last) begin
        rr.due = cyc + 2;
        rr.val = acc_mem[a];
        res_q.push_back(rr);
      end
    end
  end

  // Accumulator model output: o_valid two cycles after a last-subset issue.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      acc_o_valid = 1'b0;
      res_q.delete();
    end else if (res_q.size() > 0 && res_q[0].due <= cyc) begin
      res_t rr;
      rr = res_q.pop_front();
      acc_o_valid = 1'b1;
      if (sum_q.size() == 0) chk("unexpected_result", 1'b1, 1'b0);
      else chk("row_sum", rr.val, sum_q.pop_front());
    end else begin
      acc_o_valid = 1'b0;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_cfg_ready"}, cfg_ready, 1'b1);
    chk({tag, "_s_ready"}, s_ready, 1'b0);
    chk({tag, "_acc_valid"}, acc_valid, 1'b0);
    chk({tag, "_acc_accum"}, acc_accum, 1'b0);
    chk({tag, "_acc_last"}, acc_last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_acc_data"}, acc_data, 0);
    chk({tag, "_acc_addr"}, acc_addr, 0);
  endtask

  task automatic send_cfg(input int rm1, input int sm1, input int base);
    @(posedge clk); #1;
    cfg_valid   = 1'b1;
    cfg_rows_m1 = ADDRW'(rm1);
    cfg_subs_m1 = SUBW'(sm1);
    cfg_base    = ADDRW'(base);
    @(posedge clk); #1;
    cfg_valid   = 1'b0;
  endtask

  task automatic run_vector(input int rm1, input int sm1, input int base, input int pct,
                            input bit noise);
    int i;
    send_cfg(rm1, sm1, base);
    for (i = 0; i < 4000 && m_phase == 1; i++) begin
      s_valid = ($urandom_range(99) < pct);
      s_data  = $urandom;
      if (noise) begin
        cfg_valid   = $urandom_range(1);
        cfg_rows_m1 = ADDRW'($urandom);
        cfg_subs_m1 = SUBW'($urandom);
        cfg_base    = ADDRW'($urandom);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    cfg_valid = 1'b0;
    chk("beats_complete", m_phase != 1, 1'b1);
    for (i = 0; i < 400 && m_phase != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("vector_done", m_phase == 0, 1'b1);
    chk("issues_drained", exp_q.size(), 0);
    chk("sums_drained", sum_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    cfg_valid = 1'b0; cfg_rows_m1 = '0; cfg_subs_m1 = '0; cfg_base = '0;
    s_valid = 1'b0; s_data = '0;
    acc_o_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b1;
    @(posedge clk); #1;

    run_vector(3, 2, 0, 100, 0);     // 4 rows, 3 subsets, no stalls
    run_vector(1, 2, 5, 100, 0);     // 2 rows, 3 subsets, hazard stalls
    run_vector(0, 0, 77, 100, 0);    // single beat
    run_vector(3, 1, 510, 100, 0);   // address wrap 510,511,0,1
    run_vector(7, 1, int'($urandom_range(0, DEPTH - 1)), 50, 1);

    // Reset in the middle of a 3-subset vector.
    send_cfg(3, 2, 20);
    for (int i = 0; i < 100 && m_k < 5; i++) begin
      s_valid = 1'b1;
      s_data  = $urandom;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    s_valid = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("postrst");
    run_vector(1, 1, 30, 100, 0);

    for (int v = 0; v < 6; v++) begin
      run_vector(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(30, 100)), 1);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
